// File: rtl/cdb_writeback_arbiter_pkg.sv
// cdb_writeback_arbiter_pkg: shared widths, default sizes and the CDB result record
// Contents: SS_DEF/CDB_PORTS_DEF/QUEUE_DEPTH_DEF defaults, ROB_ID_W/PREG_W widths, cdb_entry_t
package cdb_writeback_arbiter_pkg;
    localparam int SS_DEF          = 2;
    localparam int CDB_PORTS_DEF   = 2;
    localparam int QUEUE_DEPTH_DEF = 4;
    localparam int ROB_ID_W        = 3;
    localparam int PREG_W          = 6;
    typedef struct packed {
        logic [ROB_ID_W-1:0] rob_id;
        logic [PREG_W-1:0]   pd;
        logic [4:0]          rd;
        logic [31:0]         value;
        logic                br_en;
    } cdb_entry_t;
endpackage

// File: rtl/cdb_writeback_arbiter_if.sv
// cdb_writeback_arbiter_if: FU result lanes, flush and CDB broadcast bundle
// master: drives flush/fu_*, observes fu_stall/cdb_*; slave: the arbiter side
interface cdb_writeback_arbiter_if
    import cdb_writeback_arbiter_pkg::*;
#(
    parameter int SS        = SS_DEF,
    parameter int CDB_PORTS = CDB_PORTS_DEF
);
    logic                 flush;
    logic [SS-1:0]        fu_valid;
    logic [ROB_ID_W-1:0]  fu_rob_id [SS];
    logic [PREG_W-1:0]    fu_pd [SS];
    logic [4:0]           fu_rd [SS];
    logic [31:0]          fu_value [SS];
    logic [SS-1:0]        fu_br_en;
    logic [SS-1:0]        fu_stall;
    logic [CDB_PORTS-1:0] cdb_valid;
    logic [ROB_ID_W-1:0]  cdb_rob_id [CDB_PORTS];
    logic [PREG_W-1:0]    cdb_pd [CDB_PORTS];
    logic [31:0]          cdb_value [CDB_PORTS];
    logic [CDB_PORTS-1:0] cdb_br_en;
    logic [CDB_PORTS-1:0] cdb_regf_we;
    modport master (
        output flush, fu_valid, fu_rob_id, fu_pd, fu_rd, fu_value, fu_br_en,
        input  fu_stall, cdb_valid, cdb_rob_id, cdb_pd, cdb_value, cdb_br_en, cdb_regf_we
    );
    modport slave (
        input  flush, fu_valid, fu_rob_id, fu_pd, fu_rd, fu_value, fu_br_en,
        output fu_stall, cdb_valid, cdb_rob_id, cdb_pd, cdb_value, cdb_br_en, cdb_regf_we
    );
endinterface

// File: rtl/cdb_writeback_arbiter_lane_queue.sv
// wb_lane_queue: single-lane synchronous FIFO of cdb_entry_t
// Ports: clk, rst, clear (flush), push/din, pop, head (oldest entry), full, empty
module wb_lane_queue
    import cdb_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = QUEUE_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  cdb_entry_t din,
    output cdb_entry_t head,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    cdb_entry_t  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign head    = mem[rp];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) mem[wp] <= din;
            wp  <= wp + AW'(do_push);
            rp  <= rp + AW'(do_pop);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/cdb_writeback_arbiter.sv
// cdb_writeback_arbiter: per-lane result queues drained round-robin onto registered CDB ports
// Ports: clk, rst (sync, active-high), wb (slave modport: flush, fu_* in, fu_stall/cdb_* out)
// Option: CDB_BYPASS_EN lets an empty lane's incoming result go straight to the CDB register
module cdb_writeback_arbiter
    import cdb_writeback_arbiter_pkg::*;
#(
    parameter int SS          = SS_DEF,
    parameter int CDB_PORTS   = CDB_PORTS_DEF,
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF
) (
    input logic clk,
    input logic rst,
    cdb_writeback_arbiter_if.slave wb
);
    localparam int RW = SS > 1 ? $clog2(SS) : 1;
    cdb_entry_t fu_e [SS];
    cdb_entry_t head [SS];
    cdb_entry_t src [SS];
    cdb_entry_t port_e [CDB_PORTS];
    logic [SS-1:0] full, empty, byp, elig, gnt, push, pop;
    logic [CDB_PORTS-1:0] port_v;
    logic [RW-1:0] rr_ptr, rr_nxt;
    assign wb.fu_stall = full;
    for (genvar i = 0; i < SS; i++) begin : g_lane
        assign fu_e[i] = '{rob_id: wb.fu_rob_id[i], pd: wb.fu_pd[i], rd: wb.fu_rd[i],
                           value: wb.fu_value[i], br_en: wb.fu_br_en[i]};
`ifdef CDB_BYPASS_EN
        assign byp[i] = empty[i] && wb.fu_valid[i] && !wb.flush;
`else
        assign byp[i] = 1'b0;
`endif
        assign elig[i] = (!empty[i] || byp[i]) && !wb.flush;
        assign src[i]  = byp[i] ? fu_e[i] : head[i];
        // a granted bypass result is consumed directly and must not also be queued
        assign push[i] = wb.fu_valid[i] && !full[i] && !wb.flush && !(byp[i] && gnt[i]);
        assign pop[i]  = gnt[i] && !empty[i];
        wb_lane_queue #(.DEPTH(QUEUE_DEPTH)) u_q (
            .clk   (clk),
            .rst   (rst),
            .clear (wb.flush),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (fu_e[i]),
            .head  (head[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end
    always_comb begin : arb
        int n, l;
        gnt    = '0;
        port_v = '0;
        rr_nxt = rr_ptr;
        n      = 0;
        l      = 0;
        for (int p = 0; p < CDB_PORTS; p++) port_e[p] = '0;
        for (int k = 0; k < SS; k++) begin
            l = (int'(rr_ptr) + k) % SS;
            if (elig[l] && n < CDB_PORTS) begin
                gnt[l]    = 1'b1;
                port_v[n] = 1'b1;
                port_e[n] = src[l];
                rr_nxt    = RW'((l + 1) % SS);
                n++;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst || wb.flush) begin
            rr_ptr         <= '0;
            wb.cdb_valid   <= '0;
            wb.cdb_br_en   <= '0;
            wb.cdb_regf_we <= '0;
            for (int p = 0; p < CDB_PORTS; p++) begin
                wb.cdb_rob_id[p] <= '0;
                wb.cdb_pd[p]     <= '0;
                wb.cdb_value[p]  <= '0;
            end
        end else begin
            if (|gnt) rr_ptr <= rr_nxt;
            wb.cdb_valid <= port_v;
            for (int p = 0; p < CDB_PORTS; p++) begin
                wb.cdb_rob_id[p]  <= port_e[p].rob_id;
                wb.cdb_pd[p]      <= port_e[p].pd;
                wb.cdb_value[p]   <= port_e[p].value;
                wb.cdb_br_en[p]   <= port_e[p].br_en;
                wb.cdb_regf_we[p] <= port_v[p] && |port_e[p].rd;
            end
        end
    end
endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// tb_cdb_writeback_arbiter: vector table on a 2-port instance, scoreboard sequences on a 1-port instance
module tb_cdb_writeback_arbiter;
    import cdb_writeback_arbiter_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    cdb_writeback_arbiter_if #(.SS(2), .CDB_PORTS(2)) ia ();
    cdb_writeback_arbiter_if #(.SS(2), .CDB_PORTS(1)) ib ();
    cdb_writeback_arbiter #(.SS(2), .CDB_PORTS(2), .QUEUE_DEPTH(4)) dut_a (.clk(clk), .rst(rst), .wb(ia));
    cdb_writeback_arbiter #(.SS(2), .CDB_PORTS(1), .QUEUE_DEPTH(4)) dut_b (.clk(clk), .rst(rst), .wb(ib));

    typedef struct {
        logic [1:0] v;
        cdb_entry_t in0, in1;
        logic [1:0] ev;
        cdb_entry_t e0, e1;
    } vec_t;
    vec_t tbl [6];

    int checks = 0;
    int errors = 0;
    cdb_entry_t expq [2][$];
    cdb_entry_t pend [2][$];
    int pushed [2];
    int popped [2];
    int drop [2];
    int lane_log [$];
    bit stall0_seen;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    function automatic cdb_entry_t mk(input int rob, input int pd, input int rd, input logic [31:0] v, input logic br);
        return '{rob_id: ROB_ID_W'(rob), pd: PREG_W'(pd), rd: 5'(rd), value: v, br_en: br};
    endfunction
    function automatic logic [42:0] pk(input cdb_entry_t e);
        return {e.rob_id, e.pd, e.value, e.br_en, e.rd != 5'd0};
    endfunction
    function automatic logic [42:0] pa(input int p);
        return {ia.cdb_rob_id[p], ia.cdb_pd[p], ia.cdb_value[p], ia.cdb_br_en[p], ia.cdb_regf_we[p]};
    endfunction
    function automatic logic [42:0] pb();
        return {ib.cdb_rob_id[0], ib.cdb_pd[0], ib.cdb_value[0], ib.cdb_br_en[0], ib.cdb_regf_we[0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon();
        logic [42:0] got;
        int m;
        int cnt;
        m = -1;
        if (ib.cdb_valid[0]) begin
            got = pb();
            for (int l = 0; l < 2; l++)
                if (m < 0 && expq[l].size() > 0 && pk(expq[l][0]) == got) m = l;
            checks++;
            if (m < 0) begin
                errors++;
                $display("FAIL sb_match: got %h expected a queued lane head", got);
            end else begin
                void'(expq[m].pop_front());
                popped[m]++;
                lane_log.push_back(m);
            end
        end
        for (int l = 0; l < 2; l++) begin
            cnt = pushed[l] - popped[l] - drop[l];
            chk($sformatf("stall%0d", l), 64'(ib.fu_stall[l]), 64'(cnt == 4));
        end
        if (ib.fu_stall[0]) stall0_seen = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        #1;
    endtask

    task automatic set_a(input int l, input cdb_entry_t e);
        ia.fu_rob_id[l] = e.rob_id;
        ia.fu_pd[l]     = e.pd;
        ia.fu_rd[l]     = e.rd;
        ia.fu_value[l]  = e.value;
        ia.fu_br_en[l]  = e.br_en;
    endtask
    task automatic set_b(input int l, input cdb_entry_t e);
        ib.fu_rob_id[l] = e.rob_id;
        ib.fu_pd[l]     = e.pd;
        ib.fu_rd[l]     = e.rd;
        ib.fu_value[l]  = e.value;
        ib.fu_br_en[l]  = e.br_en;
    endtask

    // stall is registered, so it is stable from here until the next posedge
    task automatic feed_b();
        for (int l = 0; l < 2; l++) begin
            if (pend[l].size() > 0) begin
                set_b(l, pend[l][0]);
                ib.fu_valid[l] = 1'b1;
                if (!ib.fu_stall[l]) begin
                    expq[l].push_back(pend[l][0]);
                    void'(pend[l].pop_front());
                    pushed[l]++;
                end
            end else begin
                ib.fu_valid[l] = 1'b0;
            end
        end
    endtask

    task automatic run_b(input int budget);
        int c;
        c = 0;
        while ((pend[0].size() + pend[1].size() + expq[0].size() + expq[1].size()) > 0 && c < budget) begin
            feed_b();
            tick();
            c++;
        end
        ib.fu_valid = '0;
        chk("drain", 64'(pend[0].size() + pend[1].size() + expq[0].size() + expq[1].size()), 64'd0);
    endtask

    task automatic discard_b();
        for (int l = 0; l < 2; l++) begin
            drop[l] += pushed[l] - popped[l] - drop[l];
            expq[l].delete();
            pend[l].delete();
        end
    endtask

    task automatic chk_b_zero(input string name);
        chk({name, "_valid"}, 64'(ib.cdb_valid), 64'd0);
        chk({name, "_fields"}, 64'(pb()), 64'd0);
        chk({name, "_stall"}, 64'(ib.fu_stall), 64'd0);
    endtask

    initial begin
        cdb_entry_t z;
        z = mk(0, 0, 0, 32'h0, 1'b0);
        tbl[0] = '{v: 2'b01, in0: mk(3, 12, 5, 32'hDEADBEEF, 1'b0), in1: z, ev: 2'b01,
                   e0: mk(3, 12, 5, 32'hDEADBEEF, 1'b0), e1: z};
        tbl[1] = '{v: 2'b10, in0: z, in1: mk(1, 9, 0, 32'h7, 1'b1), ev: 2'b01,
                   e0: mk(1, 9, 0, 32'h7, 1'b1), e1: z};
        tbl[2] = '{v: 2'b11, in0: mk(2, 3, 1, 32'h11111111, 1'b0), in1: mk(4, 5, 2, 32'h22222222, 1'b1), ev: 2'b11,
                   e0: mk(2, 3, 1, 32'h11111111, 1'b0), e1: mk(4, 5, 2, 32'h22222222, 1'b1)};
        tbl[3] = '{v: 2'b01, in0: mk(5, 40, 31, 32'hCAFEF00D, 1'b1), in1: z, ev: 2'b01,
                   e0: mk(5, 40, 31, 32'hCAFEF00D, 1'b1), e1: z};
        tbl[4] = '{v: 2'b11, in0: mk(6, 63, 0, 32'hFFFFFFFF, 1'b1), in1: mk(7, 1, 3, 32'h0, 1'b0), ev: 2'b11,
                   e0: mk(7, 1, 3, 32'h0, 1'b0), e1: mk(6, 63, 0, 32'hFFFFFFFF, 1'b1)};
        tbl[5] = '{v: 2'b10, in0: z, in1: z, ev: 2'b01, e0: z, e1: z};
        ia.flush = 1'b0;
        ib.flush = 1'b0;
        ia.fu_valid = '0;
        ib.fu_valid = '0;
        for (int l = 0; l < 2; l++) begin
            set_a(l, z);
            set_b(l, z);
            pushed[l] = 0;
            popped[l] = 0;
            drop[l] = 0;
        end
        stall0_seen = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_a_valid", 64'(ia.cdb_valid), 64'd0);
        chk("rst_a_port0", 64'(pa(0)), 64'd0);
        chk("rst_a_port1", 64'(pa(1)), 64'd0);
        chk("rst_a_stall", 64'(ia.fu_stall), 64'd0);
        chk_b_zero("rst_b");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            set_a(0, tbl[i].in0);
            set_a(1, tbl[i].in1);
            ia.fu_valid = tbl[i].v;
            tick();
            ia.fu_valid = '0;
`ifndef CDB_BYPASS_EN
            chk($sformatf("v%0d_early", i), 64'(ia.cdb_valid), 64'd0);
            tick();
`endif
            chk($sformatf("v%0d_valid", i), 64'(ia.cdb_valid), 64'(tbl[i].ev));
            chk($sformatf("v%0d_port0", i), 64'(pa(0)), 64'(tbl[i].ev[0] ? pk(tbl[i].e0) : 43'd0));
            chk($sformatf("v%0d_port1", i), 64'(pa(1)), 64'(tbl[i].ev[1] ? pk(tbl[i].e1) : 43'd0));
            tick();
            chk($sformatf("v%0d_idle", i), 64'(ia.cdb_valid), 64'd0);
        end

        lane_log.delete();
        for (int i = 0; i < 3; i++) begin
            pend[0].push_back(mk(i, i + 8, i + 1, 32'hA0000000 + i, 1'b0));
            pend[1].push_back(mk(i + 4, i + 16, i + 9, 32'hB0000000 + i, 1'b1));
        end
        run_b(60);
        begin
            int bad;
            bad = 0;
            foreach (lane_log[k]) if (lane_log[k] != k % 2) bad++;
            chk("alt_len", 64'(lane_log.size()), 64'd6);
            chk("alt_order", 64'(bad), 64'd0);
        end
        tick();

        stall0_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pend[0].push_back(mk(i, i + 20, i + 1, 32'hC0000000 + i, i[0]));
            pend[1].push_back(mk(i, i + 40, i + 2, 32'hD0000000 + i, ~i[0]));
        end
        run_b(300);
        chk("stall0_rose", 64'(stall0_seen), 64'd1);
        tick();

        for (int i = 0; i < 3; i++) pend[0].push_back(mk(i, i, 3, 32'hE0000000 + i, 1'b0));
        for (int i = 0; i < 2; i++) pend[1].push_back(mk(i, i, 4, 32'hE1000000 + i, 1'b1));
        for (int c = 0; c < 3; c++) begin
            feed_b();
            tick();
        end
        discard_b();
        ib.flush = 1'b1;
        ib.fu_valid = 2'b11;
        set_b(0, mk(7, 7, 7, 32'hF1F1F1F1, 1'b1));
        set_b(1, mk(6, 6, 6, 32'hF2F2F2F2, 1'b1));
        tick();
        ib.flush = 1'b0;
        ib.fu_valid = '0;
        chk_b_zero("flush");
        for (int c = 0; c < 4; c++) tick();
        chk("flush_quiet", 64'(ib.cdb_valid), 64'd0);
        lane_log.delete();
        pend[0].push_back(mk(1, 2, 3, 32'h01010101, 1'b0));
        pend[1].push_back(mk(2, 3, 4, 32'h02020202, 1'b0));
        run_b(20);
        chk("rr_after_flush", 64'(lane_log.size() > 0 ? lane_log[0] : 9), 64'd0);
        tick();

        for (int i = 0; i < 6; i++) begin
            pend[0].push_back(mk(i, i + 1, 5, 32'h50000000 + i, 1'b0));
            pend[1].push_back(mk(i, i + 2, 6, 32'h60000000 + i, 1'b1));
        end
        for (int c = 0; c < 4; c++) begin
            feed_b();
            tick();
        end
        discard_b();
        rst = 1'b1;
        ib.fu_valid = '0;
        tick();
        chk_b_zero("rst_mid");
        rst = 1'b0;
        tick();
        tick();
        chk("rst_quiet", 64'(ib.cdb_valid), 64'd0);
        lane_log.delete();
        pend[0].push_back(mk(3, 4, 5, 32'h03030303, 1'b1));
        pend[1].push_back(mk(4, 5, 6, 32'h04040404, 1'b0));
        run_b(20);
        chk("rr_after_rst", 64'(lane_log.size() > 0 ? lane_log[0] : 9), 64'd0);
        tick();
        chk("final_empty", 64'(expq[0].size() + expq[1].size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
